toom_8_recomposition: RTL and testbench

- Back end of the Toom-8 multiplier: consumes the 15 interpolated signed coefficients c0..c14 of the 2048-bit product, lowest first.
- Recombines them as P = sum(c_i * 2^(128*i)) with a rolling 128-bit slice adder plus a signed carry register, not a full 2048-bit adder.
- Presents the finished 2048-bit product on a valid/ready output. It is the counterpart to the operand splitter, which registers X/Y and cuts them into 8 sign-extended 129-bit chunks.

---
 rtl/toom8_pkg.sv | 11 +
 rtl/toom8_slice_adder.sv | 19 +
 rtl/toom_8_recomposition.sv | 76 +++++++
 tb/tb_toom_8_recomposition.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/toom8_pkg.sv
// toom8_pkg: Toom-8 constants and recomposition FSM states
// Shared with the operand splitter and the interpolator.
package toom8_pkg;
  localparam int TOOM8_K        = 8;
  localparam int TOOM8_SLICE_W  = 128;
  localparam int TOOM8_NUM_COEF = 2*TOOM8_K-1;
  localparam int TOOM8_COEF_W   = 272;
  localparam int TOOM8_PROD_W   = 2*TOOM8_K*TOOM8_SLICE_W;
  localparam int CARRY_W        = TOOM8_COEF_W-TOOM8_SLICE_W+2;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} recomp_state_t;
endpackage

// File: rtl/toom8_slice_adder.sv
// toom8_slice_adder: signed carry + coefficient add yielding one product slice and the next carry
// Kept separate so the wide add can be retimed on its own.
import toom8_pkg::*;
module toom8_slice_adder #(
  parameter int COEF_W = TOOM8_COEF_W,
  parameter int SLICE_W = TOOM8_SLICE_W,
  localparam int CW = COEF_W-SLICE_W+2
) (
  input  logic [CW-1:0]      carry,
  input  logic [COEF_W-1:0]  coef,
  output logic [SLICE_W-1:0] slice,
  output logic [CW-1:0]      carry_next
);
  logic [COEF_W+1:0] sum;
  // both operands sign-extended to COEF_W+2 bits, so a plain add is the signed sum
  assign sum = {{SLICE_W{carry[CW-1]}}, carry} + {{2{coef[COEF_W-1]}}, coef};
  assign slice = sum[SLICE_W-1:0];
  assign carry_next = sum[COEF_W+1:SLICE_W];
endmodule

// File: rtl/toom_8_recomposition.sv
// toom_8_recomposition: rolls 15 signed Toom-8 coefficients into the 2048-bit product
// Define TOOM8_RECOMP_OVF_CHECK_EN to flag a nonzero residual carry on ovf.
import toom8_pkg::*;
module toom_8_recomposition #(
  parameter int COEF_W = TOOM8_COEF_W,
  parameter int SLICE_W = TOOM8_SLICE_W,
  parameter int NUM_COEF = TOOM8_NUM_COEF,
  localparam int CW = COEF_W-SLICE_W+2,
  localparam int PROD_W = 2*TOOM8_K*SLICE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] product,
  output logic              frame_err,
  output logic              ovf
);
  localparam logic [3:0] LAST = 4'(NUM_COEF-1);
  recomp_state_t state, state_d;
  logic [3:0] idx;
  logic [CW-1:0] carry, carry_next;
  logic [SLICE_W-1:0] slice;
  logic accept, done;
  assign accept = coef_valid & coef_ready;
  assign done = prod_valid & prod_ready;
  toom8_slice_adder #(.COEF_W(COEF_W), .SLICE_W(SLICE_W)) u_add (
    .carry(carry), .coef(coef_data), .slice(slice), .carry_next(carry_next)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? ACCUM : IDLE;
      ACCUM:   state_d = accept && idx == LAST ? FLUSH : ACCUM;
      FLUSH:   state_d = HOLD;
      HOLD:    state_d = done ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= '0;
      product <= '0;
      coef_ready <= 1'b0;
      prod_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_d;
      coef_ready <= state_d == IDLE || state_d == ACCUM;
      // valid trails HOLD entry by one cycle so the flushed top slice is settled
      prod_valid <= state == HOLD && !done;
      if (accept) begin
        product[int'(idx)*SLICE_W +: SLICE_W] <= slice;
        carry <= carry_next;
        idx <= idx + 4'd1;
        if (coef_last != (idx == LAST)) frame_err <= 1'b1;
      end
      if (state == FLUSH) product[PROD_W-1 -: SLICE_W] <= carry[SLICE_W-1:0];
      if (done) begin
        idx <= '0;
        carry <= '0;
      end
    end
  end
`ifdef TOOM8_RECOMP_OVF_CHECK_EN
  assign ovf = prod_valid & |carry[CW-1:SLICE_W];
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_toom_8_recomposition.sv
// tb_toom_8_recomposition: random and directed coefficient sets checked against a big-integer sum model
module tb_toom_8_recomposition;
  typedef logic signed [271:0] coef_t;
  logic clk = 0, rst_n = 1, coef_valid = 0, coef_last = 0, prod_ready = 0;
  logic coef_ready, prod_valid, frame_err, ovf;
  logic [271:0] coef_data = '0;
  logic [2047:0] product, exp_prod = '0;
  logic exp_ferr = 0, exp_ovf = 0;
  int n_chk = 0, n_fail = 0;
  coef_t cs [15];

  toom_8_recomposition dut (
    .clk(clk), .rst_n(rst_n), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_last(coef_last), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .product(product), .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_prod(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < 16; k++)
        if (act[128*k +: 128] !== exp[128*k +: 128]) begin
          $display("FAIL %s slice %0d: got %h expected %h", nm, k, act[128*k +: 128], exp[128*k +: 128]);
          break;
        end
    end
  endtask

  // P = sum c_i * 2^(128 i), exact in a wide signed integer
  function automatic logic signed [2303:0] model();
    logic signed [2303:0] acc, t;
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      t = cs[i];
      acc += t <<< (128*i);
    end
    return acc;
  endfunction

  function automatic coef_t rnd();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[32*k +: 32] = $urandom;
    return coef_t'(r[271:0]) >>> $urandom_range(0, 200);
  endfunction

  task automatic send(input coef_t d, input logic l, input int i);
    int n = 0;
    coef_valid = 1;
    coef_data = d;
    coef_last = l;
    while (!coef_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("coef_ready_wait", coef_ready, 1);
    if (l != (i == 14)) exp_ferr = 1;
    @(negedge clk);
    coef_valid = 0;
    coef_last = 0;
  endtask

  task automatic run_product(input int last_pos, input int gap_max, input int hold, input logic early);
    logic signed [2303:0] acc;
    acc = model();
    exp_prod = acc[2047:0];
`ifdef TOOM8_RECOMP_OVF_CHECK_EN
    exp_ovf = (acc >>> 2048) != 0;
`else
    exp_ovf = 0;
`endif
    prod_ready = early;
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send(cs[i], i == last_pos, i);
    end
    chk("lat0_valid", prod_valid, 0);
    chk("ready_drop", coef_ready, 0);
    @(negedge clk);
    chk("lat1_valid", prod_valid, 0);
    @(negedge clk);
    chk("lat2_valid", prod_valid, 1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", prod_valid, 1);
    end
    prod_ready = 1;
    @(negedge clk);
    prod_ready = 0;
    chk("post_valid", prod_valid, 0);
    chk("post_ready", coef_ready, 1);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("frame_err", frame_err, exp_ferr);
      if (prod_valid) begin
        chk_prod("product", product, exp_prod);
        chk("ovf", ovf, exp_ovf);
      end else chk("ovf_idle", ovf, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [2303:0] acc;
    logic [2047:0] p;
    coef_t sq, m;
    #3 rst_n = 0;
    #1;
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_prod_valid", prod_valid, 0);
    chk_prod("rst_product", product, '0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    // single one in c0
    foreach (cs[i]) cs[i] = '0;
    cs[0] = 1;
    acc = model();
    chk_prod("model_one", acc[2047:0], 2048'd1);
    run_product(14, 0, 0, 0);
    // borrow from c0 = -1 resolved by c1 = 1
    foreach (cs[i]) cs[i] = '0;
    cs[0] = -1;
    cs[1] = 1;
    acc = model();
    p = '0;
    p[127:0] = '1;
    chk_prod("model_borrow", acc[2047:0], p);
    run_product(14, 2, 3, 0);
    // schoolbook coefficients of (2^1024-1)^2
    m = '0;
    m[127:0] = '1;
    sq = m * m;
    for (int k = 0; k < 15; k++) cs[k] = coef_t'(k < 7 ? k + 1 : 15 - k) * sq;
    acc = model();
    p = '1;
    p[1024:1] = '0;
    chk_prod("model_school", acc[2047:0], p);
    run_product(14, 3, 5, 0);
    // coef_last misplaced on c9
    foreach (cs[i]) cs[i] = rnd();
    run_product(9, 2, 1, 0);
    chk("ferr_sticky", frame_err, 1);
    foreach (cs[i]) cs[i] = rnd();
    run_product(14, 1, 0, 1);
    // reset after c7 aborts the product
    foreach (cs[i]) cs[i] = 3;
    for (int i = 0; i < 8; i++) send(cs[i], 0, i);
    rst_n = 0;
    exp_ferr = 0;
    #1;
    chk("mid_rst_coef_ready", coef_ready, 0);
    chk("mid_rst_prod_valid", prod_valid, 0);
    chk_prod("mid_rst_product", product, '0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1;
    acc = model();
    p = '0;
    for (int k = 0; k < 15; k++) p[128*k +: 128] = 128'd3;
    chk_prod("model_three", acc[2047:0], p);
    run_product(14, 1, 2, 0);
    // top coefficient near and past the product range
    foreach (cs[i]) cs[i] = '0;
    cs[14] = coef_t'(1) <<< 130;
    acc = model();
    chk("model_fit", (acc >>> 2048) != 0, 0);
    run_product(14, 0, 0, 0);
    cs[14] = coef_t'(1) <<< 260;
    acc = model();
    chk("model_ovf_pos", (acc >>> 2048) != 0, 1);
    run_product(14, 0, 1, 0);
    cs[14] = -1;
    run_product(14, 1, 0, 0);
    repeat (6) begin
      foreach (cs[i]) cs[i] = rnd();
      run_product(14, $urandom_range(0, 3), $urandom_range(0, 5), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
